m216a_mmd_divider: RTL and testbench

Programmable multi-modulus divider that consumes the 4-bit integer modulus stream produced by the fractional DSM core and turns it into a divided-clock pulse train. The block sits directly downstream of the DSM core. It samples one modulus per output period, counts exactly that many `clk` cycles, then requests the next modulus. `mod_ack` is the step strobe that advances the DSM, so DSM and divider stay in lock-step.

---
 rtl/m216a_pkg.sv | 17 +
 rtl/m216a_mmd_divider_if.sv | 39 +++
 rtl/m216a_mod_clamp.sv | 22 ++
 rtl/m216a_mmd_divider.sv | 89 ++++++++
 tb/tb_m216a_mmd_divider.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/m216a_pkg.sv
// Shared types and limits for the M216A DSM / multi-modulus divider pair.
package m216a_pkg;

  localparam int unsigned MOD_W = 4;

  typedef logic [MOD_W-1:0] mod_t;

  localparam mod_t MOD_MIN = mod_t'(5);
  localparam mod_t MOD_MAX = mod_t'(12);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCount
  } state_t;

endpackage

// File: rtl/m216a_mmd_divider_if.sv
// Modulus handshake and status bundle between the DSM side (master) and the divider (slave).
interface m216a_mmd_divider_if
  import m216a_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) ();

  logic             en;
  mod_t             mod_in;
  logic             err_clr;
  logic             mod_ack;
  logic             div_out;
  mod_t             cur_mod;
  logic             range_err;
  logic [CNT_W-1:0] pulse_cnt;

  modport master (
    output en,
    output mod_in,
    output err_clr,
    input  mod_ack,
    input  div_out,
    input  cur_mod,
    input  range_err,
    input  pulse_cnt
  );

  modport slave (
    input  en,
    input  mod_in,
    input  err_clr,
    output mod_ack,
    output div_out,
    output cur_mod,
    output range_err,
    output pulse_cnt
  );

endinterface

// File: rtl/m216a_mod_clamp.sv
// Clamps a raw modulus into [MOD_MIN, MOD_MAX] and flags values that needed clamping.
module m216a_mod_clamp
  import m216a_pkg::*;
(
  input  mod_t mod_in,
  output mod_t mod_clamped,
  output logic out_of_range
);

  always_comb begin
    mod_clamped  = mod_in;
    out_of_range = 1'b0;
    if (mod_in < MOD_MIN) begin
      mod_clamped  = MOD_MIN;
      out_of_range = 1'b1;
    end else if (mod_in > MOD_MAX) begin
      mod_clamped  = MOD_MAX;
      out_of_range = 1'b1;
    end
  end

endmodule

// File: rtl/m216a_mmd_divider.sv
// Multi-modulus divider: one modulus per output period, M clk cycles per period.
// Define M216A_MMD_DUTY50_EN for ~50% duty div_out instead of a single-cycle pulse.
module m216a_mmd_divider
  import m216a_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  m216a_mmd_divider_if.slave bus
);

  state_t           state_q;
  mod_t             cnt_q;
  mod_t             cur_mod_q;
  logic [CNT_W-1:0] pulse_cnt_q;
  logic             range_err_q;
  logic             div_out_q;

  mod_t mod_clamped;
  logic mod_oor;
  logic duty_hi;

  m216a_mod_clamp u_clamp (
    .mod_in       (bus.mod_in),
    .mod_clamped  (mod_clamped),
    .out_of_range (mod_oor)
  );

  // duty_hi marks the qualifying cycle; div_out follows it one cycle later.
  always_comb begin
    duty_hi = 1'b0;
`ifdef M216A_MMD_DUTY50_EN
    // k < ceil(M/2) with k = M - cnt reduces to cnt > floor(M/2).
    duty_hi = (state_q == StLoad) ||
              ((state_q == StCount) && (cnt_q > (cur_mod_q >> 1)));
`else
    duty_hi = (state_q == StLoad);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cur_mod_q   <= '0;
      pulse_cnt_q <= '0;
      range_err_q <= 1'b0;
      div_out_q   <= 1'b0;
    end else begin
      div_out_q <= duty_hi;
      if (bus.err_clr) begin
        range_err_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (bus.en) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          state_q     <= StCount;
          cur_mod_q   <= mod_clamped;
          cnt_q       <= mod_clamped - mod_t'(1);
          pulse_cnt_q <= pulse_cnt_q + CNT_W'(1);
          // Placed after the clear so a simultaneous violation keeps the flag set.
          if (mod_oor) begin
            range_err_q <= 1'b1;
          end
        end
        StCount: begin
          if (cnt_q <= mod_t'(1)) begin
            state_q <= bus.en ? StLoad : StIdle;
          end else begin
            cnt_q <= cnt_q - mod_t'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.mod_ack   = (state_q == StLoad);
  assign bus.div_out   = div_out_q;
  assign bus.cur_mod   = cur_mod_q;
  assign bus.range_err = range_err_q;
  assign bus.pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_m216a_mmd_divider.sv
// Directed bench for m216a_mmd_divider; follows M216A_MMD_DUTY50_EN when defined.
module tb_m216a_mmd_divider;

  localparam int unsigned CNT_W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  m216a_mmd_divider_if #(.CNT_W(CNT_W)) bus ();

  m216a_mmd_divider #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected div_out i cycles after an ack cycle (i = 1 is the cycle after LOAD).
  function automatic logic exp_div(int i, int m);
`ifdef M216A_MMD_DUTY50_EN
    return (i >= 1) && (i <= (m + 1) / 2);
`else
    return (i == 1);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Steps until mod_ack is seen or 40 cycles pass; n is the number of steps taken.
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.mod_ack && n < 40);
  endtask

  task automatic do_reset();
    bus.en      = 1'b0;
    bus.err_clr = 1'b0;
    bus.mod_in  = 4'd8;
    #2 rst = 1'b1;
    steps(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.mod_ack, bus.div_out, bus.cur_mod, bus.range_err, bus.pulse_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_values got ack=%b div=%b mod=%0d err=%b pc=%0d want all 0",
               bus.mod_ack, bus.div_out, bus.cur_mod, bus.range_err, bus.pulse_cnt);
    end
    step();
    checks++;
    if (bus.mod_ack !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_ack got %b want 0", bus.mod_ack);
    end
  endtask

  task automatic test_steady();
    int n;
    logic [CNT_W-1:0] exp_pc;
    do_reset();
    bus.mod_in = 4'd8;
    bus.en     = 1'b1;
    wait_ack(n);
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL en_to_ack_latency got %0d want 1", n);
    end
    for (int i = 1; i <= 24; i++) begin
      step();
      exp_pc = CNT_W'((i - 1) / 8 + 1);
      checks++;
      if (bus.mod_ack !== ((i % 8) == 0)) begin
        errors++;
        $display("FAIL steady_ack i=%0d got %b want %b", i, bus.mod_ack, (i % 8) == 0);
      end
      checks++;
      if (bus.div_out !== exp_div(i % 8, 8)) begin
        errors++;
        $display("FAIL steady_div i=%0d got %b want %b", i, bus.div_out, exp_div(i % 8, 8));
      end
      checks++;
      if (bus.pulse_cnt !== exp_pc || bus.cur_mod !== 4'd8) begin
        errors++;
        $display("FAIL steady_pc_mod i=%0d got pc=%0d mod=%0d want pc=%0d mod=8",
                 i, bus.pulse_cnt, bus.cur_mod, exp_pc);
      end
    end
  endtask

  task automatic test_sequence();
    int n;
    logic [3:0] mods [3];
    mods = '{4'd5, 4'd12, 4'd7};
    do_reset();
    bus.mod_in = mods[0];
    bus.en     = 1'b1;
    wait_ack(n);
    for (int j = 0; j < 3; j++) begin
      bus.mod_in = mods[j];
      n = 0;
      do begin
        step();
        n++;
        if (n == 1) begin
          bus.mod_in = 4'd9;
          checks++;
          if (bus.cur_mod !== mods[j]) begin
            errors++;
            $display("FAIL seq_cur_mod j=%0d got %0d want %0d", j, bus.cur_mod, mods[j]);
          end
        end
        checks++;
        if (bus.div_out !== exp_div(n, int'(mods[j]))) begin
          errors++;
          $display("FAIL seq_div j=%0d n=%0d got %b want %b",
                   j, n, bus.div_out, exp_div(n, int'(mods[j])));
        end
      end while (!bus.mod_ack && n < 40);
      checks++;
      if (n != int'(mods[j])) begin
        errors++;
        $display("FAIL seq_spacing j=%0d got %0d want %0d", j, n, mods[j]);
      end
    end
  endtask

  task automatic test_range();
    int n;
    do_reset();
    bus.mod_in = 4'd3;
    bus.en     = 1'b1;
    wait_ack(n);
    step();
    bus.mod_in = 4'd8;
    checks++;
    if (bus.cur_mod !== 4'd5 || bus.range_err !== 1'b1) begin
      errors++;
      $display("FAIL range_low got mod=%0d err=%b want mod=5 err=1", bus.cur_mod, bus.range_err);
    end
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    checks++;
    if (bus.range_err !== 1'b0) begin
      errors++;
      $display("FAIL range_clear got %b want 0", bus.range_err);
    end
    wait_ack(n);
    checks++;
    if (n + 2 != 5) begin
      errors++;
      $display("FAIL range_low_period got %0d want 5", n + 2);
    end
    bus.mod_in = 4'd15;
    step();
    bus.mod_in = 4'd8;
    checks++;
    if (bus.cur_mod !== 4'd12 || bus.range_err !== 1'b1) begin
      errors++;
      $display("FAIL range_high got mod=%0d err=%b want mod=12 err=1", bus.cur_mod, bus.range_err);
    end
    wait_ack(n);
    checks++;
    if (n + 1 != 12) begin
      errors++;
      $display("FAIL range_high_period got %0d want 12", n + 1);
    end
    bus.mod_in  = 4'd0;
    bus.err_clr = 1'b1;
    step();
    checks++;
    if (bus.range_err !== 1'b1 || bus.cur_mod !== 4'd5) begin
      errors++;
      $display("FAIL set_beats_clear got err=%b mod=%0d want err=1 mod=5",
               bus.range_err, bus.cur_mod);
    end
    bus.mod_in = 4'd7;
    step();
    bus.err_clr = 1'b0;
    checks++;
    if (bus.range_err !== 1'b0 || bus.cur_mod !== 4'd5) begin
      errors++;
      $display("FAIL clear_in_count got err=%b mod=%0d want err=0 mod=5",
               bus.range_err, bus.cur_mod);
    end
  endtask

  task automatic test_en_drop();
    int n;
    int acks;
    do_reset();
    bus.mod_in = 4'd10;
    bus.en     = 1'b1;
    wait_ack(n);
    // Drop at k=3, back at k=5: period must not be cut short.
    steps(3);
    bus.en = 1'b0;
    steps(2);
    bus.en = 1'b1;
    wait_ack(n);
    checks++;
    if (n + 5 != 10) begin
      errors++;
      $display("FAIL en_blip_period got %0d want 10", n + 5);
    end
    // Drop at k=3, back in the final COUNT cycle: no gap.
    steps(3);
    bus.en = 1'b0;
    steps(6);
    bus.en = 1'b1;
    wait_ack(n);
    checks++;
    if (n + 9 != 10) begin
      errors++;
      $display("FAIL en_last_cycle_period got %0d want 10", n + 9);
    end
    steps(3);
    bus.en = 1'b0;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.mod_ack) acks++;
    end
    checks++;
    if (acks != 0 || bus.pulse_cnt !== 4'd3) begin
      errors++;
      $display("FAIL en_drop_idle got acks=%0d pc=%0d want acks=0 pc=3", acks, bus.pulse_cnt);
    end
    bus.en = 1'b1;
    step();
    checks++;
    if (bus.mod_ack !== 1'b1) begin
      errors++;
      $display("FAIL en_reassert_latency got %b want 1", bus.mod_ack);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    bus.mod_in = 4'd14;
    bus.en     = 1'b1;
    wait_ack(n);
    steps(6);
    checks++;
    if (bus.cur_mod !== 4'd12 || bus.range_err !== 1'b1 || bus.pulse_cnt !== 4'd1) begin
      errors++;
      $display("FAIL pre_reset got mod=%0d err=%b pc=%0d want mod=12 err=1 pc=1",
               bus.cur_mod, bus.range_err, bus.pulse_cnt);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.mod_ack, bus.div_out, bus.cur_mod, bus.range_err, bus.pulse_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset got ack=%b div=%b mod=%0d err=%b pc=%0d want all 0",
               bus.mod_ack, bus.div_out, bus.cur_mod, bus.range_err, bus.pulse_cnt);
    end
    bus.mod_in = 4'd8;
    @(negedge clk);
    rst = 1'b0;
    wait_ack(n);
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL post_reset_latency got %0d want 1", n);
    end
    step();
    checks++;
    if (bus.pulse_cnt !== 4'd1 || bus.cur_mod !== 4'd8) begin
      errors++;
      $display("FAIL post_reset_pc got pc=%0d mod=%0d want pc=1 mod=8",
               bus.pulse_cnt, bus.cur_mod);
    end
  endtask

  task automatic test_wrap();
    int n;
    logic [CNT_W-1:0] exp_pc;
    do_reset();
    bus.mod_in = 4'd5;
    bus.en     = 1'b1;
    wait_ack(n);
    for (int p = 1; p <= 18; p++) begin
      step();
      exp_pc = CNT_W'(p);
      checks++;
      if (bus.pulse_cnt !== exp_pc) begin
        errors++;
        $display("FAIL pulse_cnt_wrap p=%0d got %0d want %0d", p, bus.pulse_cnt, exp_pc);
      end
      wait_ack(n);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    bus.en      = 1'b0;
    bus.err_clr = 1'b0;
    bus.mod_in  = '0;
    test_reset();
    test_steady();
    test_sequence();
    test_range();
    test_en_drop();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
